// File: rtl/slow_clk_mon_pkg.sv
// Shared types and window arithmetic for the slow-clock monitor.
// Window limits are derived from the expected half-period and tolerance.
package slow_clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCK
  } state_e;

  function automatic longint unsigned full_period(input int unsigned exp_half);
    return 64'(exp_half) << 1;
  endfunction

  function automatic longint unsigned win_lo(input int unsigned exp_half,
                                             input int unsigned tol);
    return full_period(exp_half) - 64'(tol);
  endfunction

  function automatic longint unsigned win_hi(input int unsigned exp_half,
                                             input int unsigned tol);
    return full_period(exp_half) + 64'(tol);
  endfunction

  // The counter must be able to represent one past the upper limit (a late edge).
  function automatic bit width_ok(input int unsigned exp_half,
                                  input int unsigned tol,
                                  input int unsigned cw);
    return (win_hi(exp_half, tol) + 64'd1) < (64'd1 << cw);
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Three-flop synchronizer for an asynchronous level, with a one-cycle
// rising-edge indication taken from the two settled stages.
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Converts a divided slow clock into a clk-domain tick enable, measures its
// period and tracks lock against a tolerance window around the expected period.
module slow_clk_monitor
  import slow_clk_mon_pkg::*;
#(
  parameter int unsigned EXP_HALF = 3125000,
  parameter int unsigned TOL      = 1024,
  parameter int unsigned LOCK_N   = 4,
  parameter int unsigned CW       = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          slow_in,
  output logic          tick,
  output logic [CW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          err_fast,
  output logic          err_slow
);

  localparam logic [CW-1:0] LO = CW'(win_lo(EXP_HALF, TOL));
  localparam logic [CW-1:0] HI = CW'(win_hi(EXP_HALF, TOL));
  localparam int unsigned   GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);

  if (!width_ok(EXP_HALF, TOL, CW)) begin : g_cw_too_narrow
    $error("slow_clk_monitor: CW cannot hold HI_LIM+1");
  end

  logic          rise;
  logic [CW-1:0] cnt_q, cnt_d, meas;
  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d, good_inc;
  logic [CW-1:0] period_q, period_d;
  logic          tick_q, pv_q, pv_d, ef_q, ef_d, es_q, es_d;

  sync_rise_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (slow_in),
    .rise_o (rise)
  );

  assign meas     = cnt_q + CW'(1);
  assign good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    pv_d     = 1'b0;
    ef_d     = 1'b0;
    es_d     = 1'b0;

    if (rise)            cnt_d = '0;
    else if (cnt_q != HI) cnt_d = cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK, LOCK: begin
        if (rise) begin
          // A rise coinciding with cnt == HI lands here as meas = HI+1.
          period_d = meas;
          pv_d     = 1'b1;
          if (meas < LO) begin
            ef_d    = 1'b1;
            state_d = TRACK;
            good_d  = '0;
          end else if (meas > HI) begin
            es_d    = 1'b1;
            state_d = TRACK;
            good_d  = '0;
          end else begin
            good_d = good_inc;
            if (good_inc == GOOD_MAX) state_d = LOCK;
          end
        end else if (cnt_q == HI) begin
          es_d    = 1'b1;
          state_d = IDLE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      state_q  <= IDLE;
      good_q   <= '0;
      period_q <= '0;
      tick_q   <= 1'b0;
      pv_q     <= 1'b0;
      ef_q     <= 1'b0;
      es_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      good_q   <= good_d;
      period_q <= period_d;
      tick_q   <= rise;
      pv_q     <= pv_d;
      ef_q     <= ef_d;
      es_q     <= es_d;
    end
  end

  assign tick         = tick_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = (state_q == LOCK);
  assign err_fast     = ef_q;
  assign err_slow     = es_q;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor with P=16, window 15..17, lock after 3.
module tb_slow_clk_monitor;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow_in = 1'b0;
  logic          tick, period_valid, locked, err_fast, err_slow;
  logic [CW-1:0] period;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  slow_clk_monitor #(
    .EXP_HALF (8),
    .TOL      (1),
    .LOCK_N   (3),
    .CW       (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .slow_in      (slow_in),
    .tick         (tick),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err_fast     (err_fast),
    .err_slow     (err_slow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pulses();
    return 32'({tick, period_valid, err_fast, err_slow});
  endfunction

  // One slow_in period: hi slots high then lo slots low. Its tick lands on
  // slot 3 and reports the length of the previous period.
  task automatic wave(input string tag, input int hi, input int lo,
                      input bit e_pv, input int e_per, input bit e_lock,
                      input bit e_ef, input bit e_es);
    for (int i = 0; i < hi + lo; i++) begin
      slow_in = (i < hi);
      step();
      if (i + 1 == 3) begin
        check({tag, "_tick"},   32'(tick), 32'd1);
        check({tag, "_pv"},     32'(period_valid), 32'(e_pv));
        check({tag, "_period"}, 32'(period), 32'(e_per));
        check({tag, "_locked"}, 32'(locked), 32'(e_lock));
        check({tag, "_efast"},  32'(err_fast), 32'(e_ef));
        check({tag, "_eslow"},  32'(err_slow), 32'(e_es));
      end else begin
        check({tag, "_quiet"}, pulses(), 32'd0);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    slow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slow_in = ~slow_in;
      step();
      check("reset_flags",  32'({tick, period_valid, locked, err_fast, err_slow}), 32'd0);
      check("reset_period", 32'(period), 32'd0);
    end
    rst     = 1'b0;
    slow_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset_quiet", pulses(), 32'd0);
    end

    // Steady 8/8: first tick unmeasured, lock on the 4th tick.
    wave("first_tick", 8, 8, 0, 0,  0, 0, 0);
    wave("steady_2",   8, 8, 1, 16, 0, 0, 0);
    wave("steady_3",   8, 8, 1, 16, 0, 0, 0);
    wave("steady_4",   8, 8, 1, 16, 1, 0, 0);

    // A 12-cycle period is reported on the following tick.
    wave("short_wave", 6, 6, 1, 16, 1, 0, 0);
    wave("fast_err",   8, 8, 1, 12, 0, 1, 0);
    wave("relock_1",   8, 8, 1, 16, 0, 0, 0);
    wave("relock_2",   8, 8, 1, 16, 0, 0, 0);
    // An 18-cycle period: the rise coincides with cnt == HI_LIM.
    wave("relock_3",   9, 9, 1, 16, 1, 0, 0);
    wave("slow_err",   8, 8, 1, 18, 0, 0, 1);
    wave("track_1",    8, 8, 1, 16, 0, 0, 0);
    wave("track_2",    8, 8, 1, 16, 0, 0, 0);
    wave("track_3",    8, 8, 1, 16, 1, 0, 0);

    // slow_in stuck low: tick was at slot 3, timeout at slot 21.
    slow_in = 1'b0;
    for (int s = 17; s <= 21; s++) begin
      step();
      if (s < 21) begin
        check("stall_wait_pulses", pulses(), 32'd0);
        check("stall_wait_locked", 32'(locked), 32'd1);
      end else begin
        check("timeout_eslow",  32'(err_slow), 32'd1);
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_others", 32'({tick, period_valid, err_fast}), 32'd0);
      end
    end
    step();
    check("timeout_one_cycle", pulses(), 32'd0);

    wave("after_timeout", 8, 8, 0, 16, 0, 0, 0);
    wave("regain_1",      8, 8, 1, 16, 0, 0, 0);
    wave("regain_2",      8, 8, 1, 16, 0, 0, 0);
    wave("regain_3",      8, 8, 1, 16, 1, 0, 0);

    rst = 1'b1;
    step();
    check("midlock_reset_flags",  32'({tick, period_valid, locked, err_fast, err_slow}), 32'd0);
    check("midlock_reset_period", 32'(period), 32'd0);
    rst = 1'b0;
    wave("post_rst_tick", 8, 8, 0, 0,  0, 0, 0);
    wave("post_rst_meas", 8, 8, 1, 16, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
